// File: rtl/nv_ram_rwsp_gen_pkg.sv
// Shared types and helpers for the nv_ram_rwsp_gen RAM: FSM states,
// byte-merge used by both write and bypass paths, parameter legality.
package nv_ram_pkg;

    typedef enum logic {RAM_INIT, RAM_RUN} ram_state_e;

    function automatic logic [7:0] ram_mask_merge(input logic [7:0] old_b,
                                                  input logic [7:0] new_b,
                                                  input logic       sel);
        return sel ? new_b : old_b;
    endfunction

    function automatic bit ram_params_ok(input int depth, input int width,
                                         input int aw, input int be_w);
        return (depth > 0) && (width % 8 == 0) && (be_w * 8 == width) &&
               (aw > 0) && (aw < 31) && ((1 << aw) >= depth);
    endfunction

endpackage

// File: rtl/nv_ram_rwsp_gen_if.sv
// Read/write port bundle of nv_ram_rwsp_gen; slave = RAM side.
interface nv_ram_rwsp_gen_if #(
    parameter int AW    = 6,
    parameter int WIDTH = 64
);
    localparam int BE_W = WIDTH / 8;

    logic [AW-1:0]    ra;
    logic             re;
    logic             ore;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW-1:0]    wa;
    logic             we;
    logic [BE_W-1:0]  wmask;
    logic [WIDTH-1:0] di;
    logic             init_busy;
    logic [31:0]      pwrbus_ram_pd;

    modport slave (
        input  ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        output dout, dout_vld, init_busy
    );

    modport master (
        output ra, re, ore, wa, we, wmask, di, pwrbus_ram_pd,
        input  dout, dout_vld, init_busy
    );
endinterface

// File: rtl/nv_ram_rwsp_gen_init_seq.sv
// Post-reset zeroing sequencer: walks every entry once, then hands the
// write port back to the user.
module nv_ram_init_seq
    import nv_ram_pkg::*;
#(
    parameter int DEPTH         = 61,
    parameter int AW            = 6,
    parameter int INIT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          init_busy,
    output logic          init_we,
    output logic [AW-1:0] init_wa
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    ram_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_ON_RESET != 0) ? RAM_INIT : RAM_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RAM_INIT) begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LAST) state_d = RAM_RUN;
        end
    end

    assign init_busy = (state_q == RAM_INIT);
    assign init_we   = init_busy;
    assign init_wa   = cnt_q;
endmodule

// File: rtl/nv_ram_rwsp_gen.sv
// Flat 1W/1R RAM with registered read address and output, byte masks,
// write-to-read bypass, read-valid flag and post-reset zeroing sweep.
module nv_ram_rwsp_gen
    import nv_ram_pkg::*;
#(
    parameter int DEPTH         = 61,
    parameter int WIDTH         = 64,
    parameter int AW            = 6,
    parameter int BE_W          = WIDTH / 8,
    parameter int INIT_ON_RESET = 1,
    parameter int BYPASS        = 1
) (
    input logic               clk,
    input logic               rst,
    nv_ram_rwsp_gen_if.slave  bus
);
    if (!ram_params_ok(DEPTH, WIDTH, AW, BE_W)) begin : g_param_err
        $error("nv_ram_rwsp_gen: illegal DEPTH/WIDTH/AW/BE_W combination");
    end

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    logic             init_busy, init_we;
    logic [AW-1:0]    init_wa;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data, wr_word;
    logic [BE_W-1:0]  wr_mask;
    logic [AW-1:0]    ra_d;
    logic             rd_ok;
    logic [WIDTH-1:0] ram_q, byp_data, ore_data;
    logic             byp_hit;
    logic             unused_pwr;

    nv_ram_init_seq #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .INIT_ON_RESET(INIT_ON_RESET)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .init_busy(init_busy),
        .init_we  (init_we),
        .init_wa  (init_wa)
    );

    // Sweep owns the write port while busy; out-of-range user writes are dropped.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.wa;
        wr_data = bus.di;
        wr_mask = bus.wmask;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_wa;
            wr_data = '0;
            wr_mask = '1;
        end else begin
            wr_en = bus.we && ({1'b0, bus.wa} < DEPTH_C);
        end
    end

    assign ram_q   = rd_ok ? mem[ra_d] : '0;
    assign byp_hit = (BYPASS != 0) && bus.we && rd_ok && (bus.wa == ra_d);

    for (genvar b = 0; b < BE_W; b++) begin : g_byte
        assign wr_word[8*b +: 8]  = ram_mask_merge(mem[wr_addr][8*b +: 8],
                                                   wr_data[8*b +: 8], wr_mask[b]);
        assign byp_data[8*b +: 8] = ram_mask_merge(ram_q[8*b +: 8],
                                                   bus.di[8*b +: 8], bus.wmask[b]);
    end

    assign ore_data = byp_hit ? byp_data : ram_q;

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra_d         <= '0;
            rd_ok        <= 1'b0;
            bus.dout     <= '0;
            bus.dout_vld <= 1'b0;
        end else if (!init_busy) begin
            // ore consumes the old ra_d even when re updates it this edge.
            if (bus.ore) begin
                bus.dout     <= ore_data;
                bus.dout_vld <= rd_ok;
            end
            if (bus.re) begin
                ra_d  <= bus.ra;
                rd_ok <= ({1'b0, bus.ra} < DEPTH_C);
            end
        end
    end

    assign bus.init_busy = init_busy;
    assign unused_pwr    = ^bus.pwrbus_ram_pd;
endmodule
